act_c2_scheduler: RTL

ACT_C2_SCHEDULER -- requirements
Module: act_c2_scheduler

---
 rtl/act_c2_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/act_c2_scheduler.sv
// Round-robin arbiter sharing one ACT C2 logic cell among four requesters.
// Operands are registered at grant; the cell gets one full settle cycle before capture.
module act_c2_scheduler #(
  parameter int unsigned bits = 2,
  parameter int unsigned NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*bits-1:0]   d00,
  input  logic [NREQ*bits-1:0]   d01,
  input  logic [NREQ*bits-1:0]   d10,
  input  logic [NREQ*bits-1:0]   d11,
  input  logic [4*NREQ-1:0]      sel,
  output logic [bits-1:0]        cell_D00,
  output logic [bits-1:0]        cell_D01,
  output logic [bits-1:0]        cell_D10,
  output logic [bits-1:0]        cell_D11,
  output logic                   cell_A1,
  output logic                   cell_B1,
  output logic                   cell_A0,
  output logic                   cell_B0,
  input  logic [bits-1:0]        cell_out,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [bits-1:0]        result,
  output logic [1:0]             done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [1:0]      winner;
  logic [1:0]      last_winner;
  logic [1:0]      pick;
  logic [1:0]      idx;
  logic            found;
  logic            settled;
  logic [bits-1:0] op_d00;
  logic [bits-1:0] op_d01;
  logic [bits-1:0] op_d10;
  logic [bits-1:0] op_d11;
  logic [3:0]      op_sel;

  // The cell only ever sees registered operands.
  assign cell_D00 = op_d00;
  assign cell_D01 = op_d01;
  assign cell_D10 = op_d10;
  assign cell_D11 = op_d11;
  assign cell_A1  = op_sel[3];
  assign cell_B1  = op_sel[2];
  assign cell_A0  = op_sel[1];
  assign cell_B0  = op_sel[0];

  // Round-robin search starting just after the last winner.
  always_comb begin
    pick  = 2'(last_winner + 2'd1);
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = 2'(last_winner + 2'(i) + 2'd1);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = EVAL;
      EVAL:    if (settled) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      gnt         <= '0;
      done        <= 1'b0;
      result      <= '0;
      done_id     <= 2'd0;
      winner      <= 2'd0;
      last_winner <= 2'd3;
      settled     <= 1'b0;
      op_d00      <= '0;
      op_d01      <= '0;
      op_d10      <= '0;
      op_d11      <= '0;
      op_sel      <= 4'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (|req) begin
            winner  <= pick;
            gnt     <= NREQ'(1) << pick;
            settled <= 1'b0;
            op_d00  <= d00[pick*bits +: bits];
            op_d01  <= d01[pick*bits +: bits];
            op_d10  <= d10[pick*bits +: bits];
            op_d11  <= d11[pick*bits +: bits];
            op_sel  <= sel[pick*4 +: 4];
          end
        end
        // First EVAL cycle lets the cell settle; the second one captures.
        EVAL: begin
          settled <= 1'b1;
          if (settled) begin
            result  <= cell_out;
            done_id <= winner;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done        <= 1'b0;
          gnt         <= '0;
          last_winner <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule
